header_nonce_feeder: RTL and testbench

//  Upstream stage of the bitcoin miner AXIS wrapper.

---
 rtl/header_nonce_feeder_pkg.sv | 17 +
 rtl/header_nonce_feeder.sv | 152 +++++++++++++++
 tb/tb_header_nonce_feeder.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/header_nonce_feeder_pkg.sv
// Shared constants and FSM encoding for the header/nonce feeder ahead of the miner core.
package header_nonce_feeder_pkg;

  localparam int DEF_AXIS_WIDTH   = 32;
  localparam int DEF_HEADER_WORDS = 20;
  localparam int DEF_LOAD_WORDS   = 21;
  localparam int NONCE_WORD_IDX   = DEF_HEADER_WORDS - 1;
  localparam int IDX_W            = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SEND  = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/header_nonce_feeder.sv
// Purpose: take one load frame (template + nonce range) and emit one header frame per nonce.
// Latency: first header word valid 1 cycle after the last accepted load word.
// Backpressure: m_axis holds word/data while tready is low; s_axis accepts only in LOAD/DRAIN.
module header_nonce_feeder
  import header_nonce_feeder_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = DEF_AXIS_WIDTH,
  parameter int HEADER_WORDS       = DEF_HEADER_WORDS,
  parameter int LOAD_WORDS         = DEF_LOAD_WORDS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tstrb,
  input  logic                            m_axis_tready,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            load_err,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   cur_nonce
);

  localparam int TMPL_WORDS = HEADER_WORDS - 1;
  localparam logic [IDX_W-1:0] NONCE_IDX = IDX_W'(NONCE_WORD_IDX);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(HEADER_WORDS - 1);
  localparam logic [IDX_W-1:0] START_IDX = IDX_W'(LOAD_WORDS - 2);
  localparam logic [IDX_W-1:0] END_IDX   = IDX_W'(LOAD_WORDS - 1);

  feeder_state_t state_q, state_d;

  logic [C_AXIS_TDATA_WIDTH-1:0] tmpl [0:TMPL_WORDS-1];
  logic [C_AXIS_TDATA_WIDTH-1:0] nonce_start_q;
  logic [C_AXIS_TDATA_WIDTH-1:0] nonce_end_q;
  logic [C_AXIS_TDATA_WIDTH-1:0] nonce_q;
  logic [IDX_W-1:0]              load_idx_q;
  logic [IDX_W-1:0]              word_idx_q;
  logic                          abort_q;
  logic                          done_q;
  logic                          load_err_q;

  logic s_hs;
  logic m_hs;
  logic frame_end;
  logic abort_any;
  logic sweep_end;
  logic done_d;
  logic load_err_d;

  assign s_axis_tready = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign m_axis_tvalid = (state_q == ST_SEND);
  assign m_axis_tlast  = (state_q == ST_SEND) && (word_idx_q == LAST_WORD);
  assign m_axis_tstrb  = '1;
  assign m_axis_tdata  = (state_q != ST_SEND)  ? '0 :
                         (word_idx_q < NONCE_IDX) ? tmpl[word_idx_q] : nonce_q;

  assign s_hs      = s_axis_tvalid && s_axis_tready;
  assign m_hs      = m_axis_tvalid && m_axis_tready;
  assign frame_end = m_hs && m_axis_tlast;
  assign abort_any = abort || abort_q;
  // An abort raised during the final word still counts for that frame boundary.
  assign sweep_end = (nonce_q == nonce_end_q) || abort_any;

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign load_err  = load_err_q;
  assign cur_nonce = nonce_q;

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_axis_tvalid) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort_any) begin
          state_d = ST_IDLE;
        end else if (s_hs) begin
          if (load_idx_q == END_IDX) begin
            state_d = s_axis_tlast ? ST_SEND : ST_DRAIN;
          end else if (s_axis_tlast) begin
            state_d    = ST_IDLE;
            load_err_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (abort_any)                  state_d = ST_IDLE;
        else if (s_hs && s_axis_tlast)  state_d = ST_SEND;
      end
      ST_SEND: begin
        if (frame_end && sweep_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TMPL_WORDS; i++) tmpl[i] <= '0;
      nonce_start_q <= '0;
      nonce_end_q   <= '0;
      nonce_q       <= '0;
      load_idx_q    <= '0;
      word_idx_q    <= '0;
      abort_q       <= 1'b0;
      done_q        <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      done_q     <= done_d;
      load_err_q <= load_err_d;
      abort_q    <= (state_d != ST_IDLE) &&
                    (abort_q || (abort && (state_q != ST_IDLE)));

      if (state_q == ST_IDLE) begin
        load_idx_q <= '0;
      end else if ((state_q == ST_LOAD) && s_hs) begin
        load_idx_q <= load_idx_q + 1'b1;
        if (load_idx_q < NONCE_IDX) tmpl[load_idx_q] <= s_axis_tdata;
        if (load_idx_q == START_IDX) nonce_start_q <= s_axis_tdata;
        if (load_idx_q == END_IDX)   nonce_end_q   <= s_axis_tdata;
      end

      // nonce_start was captured on an earlier handshake, so it is settled here.
      if ((state_d == ST_SEND) && (state_q != ST_SEND)) begin
        nonce_q <= nonce_start_q;
      end else if (frame_end && !sweep_end) begin
        nonce_q <= nonce_q + 1'b1;
      end

      if (m_hs) begin
        word_idx_q <= m_axis_tlast ? '0 : word_idx_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_header_nonce_feeder.sv
// Scoreboard bench: stimulus pushes expected header words, a negedge monitor pops and compares.
module tb_header_nonce_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic [3:0]  m_axis_tstrb;
  logic        m_axis_tready = 1'b1;
  logic        abort = 1'b0;
  logic        busy;
  logic        done;
  logic        load_err;
  logic [31:0] cur_nonce;

  header_nonce_feeder dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tstrb(m_axis_tstrb),
    .m_axis_tready(m_axis_tready), .abort(abort),
    .busy(busy), .done(done), .load_err(load_err), .cur_nonce(cur_nonce)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        last;
    logic        fin;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pop = 0;
  bit          pend_done = 0;
  bit          rnd_ready = 0;
  logic [31:0] lw [0:31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  // Reference: frames for nonces start, start+1, ... (mod 2^32) up to end, cut short after max_frames.
  task automatic push_sweep(input int max_frames);
    logic [31:0] n;
    bit          fin;
    n = lw[19];
    for (int f = 0; f < max_frames; f++) begin
      fin = (n == lw[20]) || (f == max_frames - 1);
      for (int w = 0; w < 19; w++) sbq.push_back('{d: lw[w], last: 1'b0, fin: 1'b0});
      sbq.push_back('{d: n, last: 1'b1, fin: fin});
      if (fin) break;
      n = n + 32'd1;
    end
  endtask

  task automatic do_load(input int n);
    int b;
    for (int i = 0; i < n; i++) begin
      s_axis_tdata  = lw[i];
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (i == n - 1);
      b = 0;
      while (!s_axis_tready && b < 100) begin
        @(negedge clk);
        b++;
      end
      if (b >= 100) fail("load_stall");
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while ((sbq.size() != 0 || busy || pend_done) && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (c >= budget) fail("sweep_timeout");
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_template();
    for (int i = 0; i < 19; i++) lw[i] = $urandom;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  bit          hold_vld = 0;
  logic [31:0] hold_dat;
  logic        hold_last;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pend_done) begin
          chk("done_pulse", {31'd0, done}, 32'd1);
          pend_done = 0;
        end else if (done) begin
          fail("spurious_done");
        end
        if (hold_vld) begin
          chk("hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
          chk("hold_data", m_axis_tdata, hold_dat);
          chk("hold_last", {31'd0, m_axis_tlast}, {31'd0, hold_last});
        end
        hold_vld  = m_axis_tvalid && !m_axis_tready;
        hold_dat  = m_axis_tdata;
        hold_last = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
          if (sbq.size() == 0) begin
            fail("unexpected_word");
          end else begin
            e = sbq.pop_front();
            chk("m_tdata", m_axis_tdata, e.d);
            chk("m_tlast", {31'd0, m_axis_tlast}, {31'd0, e.last});
            chk("m_tstrb", {28'd0, m_axis_tstrb}, 32'hF);
            if (e.fin) pend_done = 1;
            n_pop++;
          end
        end
      end
    end
  end

  initial begin
    int base;
    int c;
    @(negedge clk);
    chk("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_m_tdata", m_axis_tdata, 32'd0);
    chk("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_load_err", {31'd0, load_err}, 32'd0);
    chk("rst_cur_nonce", cur_nonce, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Sequential template, three nonces.
    for (int i = 0; i < 19; i++) lw[i] = i;
    lw[19] = 32'd5; lw[20] = 32'd7;
    push_sweep(1000);
    do_load(21);
    chk("first_word_latency", {31'd0, m_axis_tvalid}, 32'd1);
    wait_idle(500);
    chk("t1_cur_nonce", cur_nonce, 32'd7);

    // Range wrapping through 0xFFFFFFFF, with backpressure.
    rnd_ready = 1;
    rand_template();
    lw[19] = 32'hFFFF_FFFE; lw[20] = 32'd1;
    push_sweep(1000);
    do_load(21);
    wait_idle(2000);
    chk("t2_cur_nonce", cur_nonce, 32'd1);

    // Single-frame sweep under backpressure.
    rand_template();
    lw[19] = 32'd9; lw[20] = 32'd9;
    push_sweep(1000);
    do_load(21);
    wait_idle(1000);
    chk("t3_cur_nonce", cur_nonce, 32'd9);

    // Short load frame: error pulse, nothing emitted.
    rnd_ready = 0;
    rand_template();
    do_load(11);
    chk("short_load_err", {31'd0, load_err}, 32'd1);
    repeat (5) @(negedge clk);
    chk("short_busy", {31'd0, busy}, 32'd0);
    chk("short_err_pulse", {31'd0, load_err}, 32'd0);

    // Oversized load: extra words drained, first 21 words used.
    rand_template();
    lw[19] = 32'd40; lw[20] = 32'd41;
    lw[21] = $urandom; lw[22] = $urandom;
    push_sweep(1000);
    do_load(23);
    wait_idle(1000);
    chk("t5_cur_nonce", cur_nonce, 32'd41);

    // Abort mid-frame 2 of a long sweep.
    rand_template();
    lw[19] = 32'd0; lw[20] = 32'd100;
    base = n_pop;
    push_sweep(2);
    do_load(21);
    c = 0;
    while (n_pop < base + 28 && c < 500) begin
      @(negedge clk);
      c++;
    end
    if (c >= 500) fail("abort_wait");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_idle(500);
    chk("abort_cur_nonce", cur_nonce, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);

    // Random short sweeps, random extra load words, random backpressure.
    rnd_ready = 1;
    for (int t = 0; t < 4; t++) begin
      rand_template();
      lw[19] = $urandom;
      lw[20] = lw[19] + 32'($urandom_range(0, 2));
      lw[21] = $urandom; lw[22] = $urandom;
      push_sweep(1000);
      do_load(21 + int'($urandom_range(0, 2)));
      wait_idle(2000);
      chk("rand_cur_nonce", cur_nonce, lw[20]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
